// File: rtl/activation_pingpong_buffer_pkg.sv
// rtl/activation_pingpong_buffer_pkg.sv - shared buffer definitions
// Bank count, default lane geometry shared with the PE feeder, lane-slice helper.
package activation_pingpong_buffer_pkg;

  localparam int NUM_BANKS      = 2;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LANE_WIDTH = 7;
  localparam int DEF_LANES      = 4;

  typedef logic [NUM_BANKS-1:0] bank_mask_t;

  // Low bit index of a lane within a packed activation word.
  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/activation_pingpong_buffer_if.sv
// rtl/activation_pingpong_buffer_if.sv - writer/reader bus of the activation ping-pong buffer
// master = loader/feeder side, slave = buffer side.
interface activation_pingpong_buffer_if
  import activation_pingpong_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int LANES      = DEF_LANES
);
  localparam int DW = LANES * LANE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]      wr_lane_en;
  logic [DW-1:0]         wr_data;
  logic                  wr_done;
  logic                  wr_bank_ready;
  logic                  wr_bank_sel;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic                  rd_bank_ready;
  logic                  rd_bank_sel;
  logic [DW-1:0]         rd_data;
  logic                  rd_valid;
  logic                  wr_err;
  logic                  rd_err;

  modport master (
    output wr_en, wr_addr, wr_lane_en, wr_data, wr_done,
    output rd_en, rd_addr, rd_done,
    input  wr_bank_ready, wr_bank_sel, rd_bank_ready, rd_bank_sel,
    input  rd_data, rd_valid, wr_err, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_lane_en, wr_data, wr_done,
    input  rd_en, rd_addr, rd_done,
    output wr_bank_ready, wr_bank_sel, rd_bank_ready, rd_bank_sel,
    output rd_data, rd_valid, wr_err, rd_err
  );

endinterface

// File: rtl/sdp_lane_ram.sv
// rtl/sdp_lane_ram.sv - simple dual-port RAM, per-lane write enable, registered read
// Contents are never reset; the read register holds while re is low.
module sdp_lane_ram
  import activation_pingpong_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [LANES-1:0]            wlane_en,
  input  logic [LANES*LANE_WIDTH-1:0] wdata,
  input  logic                        re,
  input  logic [ADDR_WIDTH-1:0]       raddr,
  output logic [LANES*LANE_WIDTH-1:0] rdata
);
  localparam int DW    = LANES * LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wlane_en[i]) begin
        mem_q[waddr][lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH] <= wdata[lane_lsb(i, LANE_WIDTH) +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/activation_pingpong_buffer.sv
// rtl/activation_pingpong_buffer.sv - double-buffered activation store, loader -> PE feeder
// Bank ownership moves via wr_done/rd_done; full[] decides who owns which bank.
module activation_pingpong_buffer
  import activation_pingpong_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LANE_WIDTH   = DEF_LANE_WIDTH,
  parameter int LANES        = DEF_LANES,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  activation_pingpong_buffer_if.slave   bus
);
  localparam int DW = LANES * LANE_WIDTH;

  bank_mask_t full_q, full_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_err_q, wr_err_d;
  logic       rd_err_q, rd_err_d;
  logic       rd_sel_q, rd_sel_d;
  logic       rd_seen_q, rd_seen_d;
  logic       rd_vld1_q, rd_vld1_d;

  logic       wr_ready, rd_ready;
  logic       wr_fire, wr_done_fire, rd_fire, rd_done_fire;
  bank_mask_t bank_we, bank_re;

  logic [DW-1:0] bank_rdata [NUM_BANKS];
  logic [DW-1:0] mux_data;
  logic [DW-1:0] stage1_data;

  always_comb begin
    wr_ready     = ~full_q[wr_ptr_q];
    rd_ready     = full_q[rd_ptr_q];
    wr_fire      = bus.wr_en & wr_ready;
    wr_done_fire = bus.wr_done & wr_ready;
    rd_fire      = bus.rd_en & rd_ready;
    rd_done_fire = bus.rd_done & rd_ready;

    bank_we           = '0;
    bank_we[wr_ptr_q] = wr_fire;
    bank_re           = '0;
    bank_re[rd_ptr_q] = rd_fire;

    // Both handoffs can fire together: a ready writer and ready reader never share a bank.
    full_d = full_q;
    if (wr_done_fire) full_d[wr_ptr_q] = 1'b1;
    if (rd_done_fire) full_d[rd_ptr_q] = 1'b0;

    wr_ptr_d = wr_ptr_q ^ wr_done_fire;
    rd_ptr_d = rd_ptr_q ^ rd_done_fire;
    wr_err_d = wr_err_q | ((bus.wr_en | bus.wr_done) & ~wr_ready);
    rd_err_d = rd_err_q | ((bus.rd_en | bus.rd_done) & ~rd_ready);

    // Output mux follows the bank of the last accepted read, so rd_data holds between reads.
    rd_sel_d  = rd_fire ? rd_ptr_q : rd_sel_q;
    rd_seen_d = rd_seen_q | rd_fire;
    rd_vld1_d = rd_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_seen_q <= 1'b0;
      rd_vld1_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      rd_sel_q  <= rd_sel_d;
      rd_seen_q <= rd_seen_d;
      rd_vld1_q <= rd_vld1_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sdp_lane_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE_WIDTH (LANE_WIDTH),
      .LANES      (LANES)
    ) u_ram (
      .clk      (clk),
      .we       (bank_we[b]),
      .waddr    (bus.wr_addr),
      .wlane_en (bus.wr_lane_en),
      .wdata    (bus.wr_data),
      .re       (bank_re[b]),
      .raddr    (bus.rd_addr),
      .rdata    (bank_rdata[b])
    );
  end

  // RAM read registers are not reset; rd_seen masks them to zero until a read completes.
  assign mux_data    = bank_rdata[rd_sel_q];
  assign stage1_data = rd_seen_q ? mux_data : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_vld2_q, rd_vld2_d;

    always_comb begin
      rd_vld2_d = rd_vld1_q;
      rd_data_d = rd_vld1_q ? stage1_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q <= '0;
        rd_vld2_q <= 1'b0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_vld2_q <= rd_vld2_d;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_vld2_q;
  end else begin : g_lat1
    assign bus.rd_data  = stage1_data;
    assign bus.rd_valid = rd_vld1_q;
  end

  assign bus.wr_bank_ready = wr_ready;
  assign bus.rd_bank_ready = rd_ready;
  assign bus.wr_bank_sel   = wr_ptr_q;
  assign bus.rd_bank_sel   = rd_ptr_q;
  assign bus.wr_err        = wr_err_q;
  assign bus.rd_err        = rd_err_q;

endmodule

// File: tb/tb_activation_pingpong_buffer.sv
// tb/tb_activation_pingpong_buffer.sv - scoreboard bench for activation_pingpong_buffer
module tb_activation_pingpong_buffer;
  import activation_pingpong_buffer_pkg::*;

  localparam int AW = 10;
  localparam int LW = 7;
  localparam int LN = 4;
  localparam int DW = LN * LW;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  activation_pingpong_buffer_if #(.ADDR_WIDTH(AW), .LANE_WIDTH(LW), .LANES(LN)) bus ();

  activation_pingpong_buffer #(
    .ADDR_WIDTH   (AW),
    .LANE_WIDTH   (LW),
    .LANES        (LN),
    .READ_LATENCY (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   valid_cnt = 0;
  int   v0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      valid_cnt++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rd_valid act data=%h cyc=%0d req no read pending", bus.rd_data, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.rd_data === e.data && cyc == e.due) passes++;
        else $display("FAIL rd_data act=%h@cyc%0d req=%h@cyc%0d", bus.rd_data, cyc, e.data, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_lane_en = '0;
    bus.wr_data    = '0;
    bus.wr_done    = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_done    = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s act=%h req=%h", name, act, req);
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [LN-1:0] le, input logic [DW-1:0] d);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = a;
    bus.wr_lane_en = le;
    bus.wr_data    = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_data);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    if (expect_data) sb.push_back('{data: d, due: cyc + RL});
  endtask

  task automatic chk_flags(input string tag, input logic wrdy, input logic wsel,
                           input logic rrdy, input logic rsel);
    chk({tag, "_wr_bank_ready"}, 32'(bus.wr_bank_ready), 32'(wrdy));
    chk({tag, "_wr_bank_sel"},   32'(bus.wr_bank_sel),   32'(wsel));
    chk({tag, "_rd_bank_ready"}, 32'(bus.rd_bank_ready), 32'(rrdy));
    chk({tag, "_rd_bank_sel"},   32'(bus.rd_bank_sel),   32'(rsel));
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data",  32'(bus.rd_data),  32'd0);
    chk("reset_wr_err",   32'(bus.wr_err),   32'd0);
    chk("reset_rd_err",   32'(bus.rd_err),   32'd0);
    rst_n = 1'b1;
    tick();

    // Fill bank0 and a lane-masked word at addr 5, then hand it off.
    for (int k = 0; k < 4; k++) begin
      set_wr(AW'(k), 4'b1111, 28'h1234567 + 28'(k));
      tick();
      clr();
    end
    set_wr(10'd5, 4'b1111, 28'hFFFFFFF); tick(); clr();
    set_wr(10'd5, 4'b0101, 28'h0000000); tick(); clr();
    bus.wr_done = 1'b1; tick(); clr();
    chk_flags("fill", 1'b1, 1'b1, 1'b1, 1'b0);

    set_rd(10'd2, 28'h1234569, 1'b1); tick(); clr();
    set_rd(10'd5, 28'hFE03F80, 1'b1); tick(); clr();

    // Reader drains bank0 while the writer fills bank1 at the same addresses.
    for (int k = 0; k < 4; k++) begin
      set_wr(AW'(k), 4'b1111, 28'h0AAAAA0 + 28'(k));
      set_rd(AW'(k), 28'h1234567 + 28'(k), 1'b1);
      tick();
      clr();
    end
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    tick(); clr();
    chk_flags("swap", 1'b1, 1'b0, 1'b1, 1'b1);
    set_rd(10'd1, 28'h0AAAAA1, 1'b1); tick(); clr();

    // Fill bank0 too: both full, writer must stall and drop writes.
    set_wr(10'd0, 4'b1111, 28'h0111111); tick(); clr();
    bus.wr_done = 1'b1; tick(); clr();
    chk_flags("both_full", 1'b0, 1'b1, 1'b1, 1'b1);
    set_wr(10'd0, 4'b1111, 28'h7777777); tick(); clr();
    chk("drop_wr_err", 32'(bus.wr_err), 32'd1);
    bus.wr_done = 1'b1; tick(); clr();
    chk_flags("drop_done", 1'b0, 1'b1, 1'b1, 1'b1);
    set_rd(10'd0, 28'h0AAAAA0, 1'b1); tick(); clr();

    // Read and release in the same cycle: data comes from bank1.
    set_rd(10'd1, 28'h0AAAAA1, 1'b1);
    bus.rd_done = 1'b1;
    tick(); clr();
    chk_flags("rd_release", 1'b1, 1'b1, 1'b1, 1'b0);
    set_rd(10'd0, 28'h0111111, 1'b1); tick(); clr();
    set_rd(10'd2, 28'h1234569, 1'b1); tick(); clr();
    chk("wr_err_sticky", 32'(bus.wr_err), 32'd1);
    chk("rd_err_clean",  32'(bus.rd_err), 32'd0);

    // Empty both banks: reads are dropped and flagged.
    bus.rd_done = 1'b1; tick(); clr();
    chk_flags("empty", 1'b1, 1'b1, 1'b0, 1'b1);
    set_rd(10'd0, '0, 1'b0); tick(); clr();
    chk("empty_rd_err", 32'(bus.rd_err), 32'd1);
    bus.rd_done = 1'b1; tick(); clr();
    chk_flags("empty_done", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    // Reset one cycle after an accepted read: the read must vanish.
    set_wr(10'd7, 4'b1111, 28'h0ABCDEF); tick(); clr();
    bus.wr_done = 1'b1; tick(); clr();
    chk_flags("pre_rst", 1'b1, 1'b0, 1'b1, 1'b1);
    v0 = valid_cnt;
    set_rd(10'd7, '0, 1'b0); tick(); clr();
    rst_n = 1'b0;
    #1;
    chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_rd_data",  32'(bus.rd_data),  32'd0);
    chk("mid_rst_wr_err",   32'(bus.wr_err),   32'd0);
    chk("mid_rst_rd_err",   32'(bus.rd_err),   32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_valid", 32'(valid_cnt), 32'(v0));

    // RAM contents survive reset.
    bus.wr_done = 1'b1; tick(); clr();
    set_rd(10'd2, 28'h1234569, 1'b1); tick(); clr();

    repeat (4) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
